// File: rtl/xor_arbiter_pkg.sv
// xor_arbiter_pkg: shared types and defaults for the XOR arbiter slice.
//   state_t   - arbiter FSM state encoding
//   DEF_NREQ  - default requester count
//   DEF_W     - default operand/result width
package xor_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 8;

endpackage

// File: rtl/xor_arbiter_xor_unit.sv
// xor_unit: W-bit combinational XOR built from AND/OR/NOT terms.
//   a, b - operands
//   y    - (a & ~b) | (~a & b)
module xor_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = (a & ~b) | (~a & b);

endmodule

// File: rtl/xor_arbiter.sv
// xor_arbiter: round-robin arbiter sharing one XOR unit among NREQ requesters.
// Each operation runs LOAD -> EXEC -> RESP; a pending request in RESP
// goes straight back to LOAD, giving one result every three cycles.
//   clk, rst_n - clock, async active-low reset
//   req        - per-requester request level
//   a_in, b_in - packed operands, requester i at [i*W +: W]
//   gnt        - one-hot grant during LOAD/EXEC
//   busy       - state is not IDLE
//   res        - result register (held between strobes)
//   res_valid  - one-cycle strobe in RESP
//   res_id     - requester owning res
module xor_arbiter
  import xor_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       a_in,
  input  logic [NREQ*W-1:0]       b_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [W-1:0]            res,
  output logic                    res_valid,
  output logic [$clog2(NREQ)-1:0] res_id
);

  localparam int IW = $clog2(NREQ);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  xor_y;

  logic [IW-1:0] pick;
  logic [IW-1:0] ptr_nxt;
  int            idx;

  // Walk offsets from the top down so the lowest offset from ptr that
  // has a request is the last one written, i.e. the round-robin winner.
  always_comb begin
    pick = ptr;
    idx  = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NREQ;
      if (req[idx]) pick = IW'(idx);
    end
    ptr_nxt = IW'((int'(pick) + 1) % NREQ);
  end

  xor_unit #(.W(W)) u_xor (
    .a (op_a),
    .b (op_b),
    .y (xor_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      winner <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= LOAD;
            winner <= pick;
            ptr    <= ptr_nxt;
          end
        end
        LOAD: begin
          // Operands are captured once here; later input changes are ignored.
          op_a  <= a_in[int'(winner)*W +: W];
          op_b  <= b_in[int'(winner)*W +: W];
          state <= EXEC;
        end
        EXEC: begin
          res   <= xor_y;
          state <= RESP;
        end
        RESP: begin
          if (|req) begin
            state  <= LOAD;
            winner <= pick;
            ptr    <= ptr_nxt;
          end else begin
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    gnt = '0;
    if (state == LOAD || state == EXEC) gnt[winner] = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == RESP);
  assign res_id    = winner;

endmodule

// File: tb/tb_xor_arbiter.sv
module tb_xor_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req;
  logic [N*W-1:0]      a_in;
  logic [N*W-1:0]      b_in;
  logic [N-1:0]        gnt;
  logic                busy;
  logic [W-1:0]        res;
  logic                res_valid;
  logic [$clog2(N)-1:0] res_id;

  int passed = 0;
  int total  = 0;
  int m_ptr  = 0;
  logic [W-1:0] last_res = '0;

  always #5 clk = ~clk;

  xor_arbiter #(.NREQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .res       (res),
    .res_valid (res_valid),
    .res_id    (res_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin: first requester at or after p, wrapping.
  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int o = 0; o < N; o++)
      if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},  gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res"},  res, 0);
    chk({tag, "_vld"},  res_valid, 0);
    chk({tag, "_id"},   res_id, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_zero("rst");
    step();
    chk("rst_hold_vld", res_valid, 0);
    step();
    rst_n   = 1'b1;
    m_ptr    = 0;
    last_res = '0;
  endtask

  // Called in IDLE or RESP with req/operands already set; returns in RESP.
  task automatic txn(input bit mutate);
    int w;
    logic [W-1:0] ea, eb;
    w  = rr_pick(m_ptr, req);
    m_ptr = (w + 1) % N;
    ea = a_in[w*W +: W];
    eb = b_in[w*W +: W];
    step();
    chk("load_gnt",  gnt, 32'(1) << w);
    chk("load_busy", busy, 1);
    chk("load_vld",  res_valid, 0);
    step();
    chk("exec_gnt",  gnt, 32'(1) << w);
    chk("exec_vld",  res_valid, 0);
    if (mutate) begin
      req[w] = 1'b0;
      a_in[w*W +: W] = 8'hFF;
      b_in[w*W +: W] = W'($urandom);
    end
    step();
    chk("resp_vld",  res_valid, 1);
    chk("resp_id",   res_id, w);
    chk("resp_res",  res, ea ^ eb);
    chk("resp_gnt",  gnt, 0);
    chk("resp_busy", busy, 1);
    last_res = ea ^ eb;
  endtask

  task automatic go_idle();
    req = '0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_vld",  res_valid, 0);
    chk("idle_gnt",  gnt, 0);
    chk("idle_hold", res, last_res);
  endtask

  task automatic rand_ops();
    a_in = {$urandom, $urandom};
    b_in = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    #1;
    chk_zero("por");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle0_busy", busy, 0);

    // single requester, known operands
    req = 4'b0001;
    a_in[0 +: W] = 8'hF0;
    b_in[0 +: W] = 8'h3C;
    txn(1'b0);
    chk("cc_res", res, 8'hCC);
    chk("cc_id",  res_id, 0);
    go_idle();

    // all requesting: 0,1,2,3,0 back to back
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      txn(1'b0);
    end
    go_idle();

    // only req[3], then 1001 -> pointer wraps to 0
    do_reset();
    rand_ops();
    req = 4'b1000;
    txn(1'b0);
    req = 4'b1001;
    rand_ops();
    txn(1'b0);
    chk("wrap_id", res_id, 0);
    go_idle();

    // drop req and corrupt operand during EXEC
    req = 4'b0100;
    rand_ops();
    txn(1'b1);
    chk("drop_id", res_id, 2);
    go_idle();

    // equal operands then complementary
    req = 4'b0001;
    a_in[0 +: W] = 8'hAA;
    b_in[0 +: W] = 8'hAA;
    txn(1'b0);
    chk("eq_res", res, 8'h00);
    a_in[0 +: W] = 8'h00;
    b_in[0 +: W] = 8'hFF;
    txn(1'b0);
    chk("cmp_res", res, 8'hFF);
    go_idle();

    // reset during EXEC
    req = 4'b0110;
    rand_ops();
    step();
    chk("pre_rst_gnt", gnt, 4'b0010 << (rr_pick(m_ptr, req) - 1));
    step();
    req = 4'b1010;
    do_reset();
    rand_ops();
    txn(1'b0);
    chk("post_rst_id", res_id, 1);
    go_idle();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      req = N'($urandom_range(1, 15));
      rand_ops();
      txn(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one XOR unit.
REQ-002 SHALL have parameter W, default 8, operand and result width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester request level.
REQ-006 SHALL have port a_in  input  NREQ*W  operand A, requester i in bits [i*W +: W].
REQ-007 SHALL have port b_in  input  NREQ*W  operand B, same packing as a_in.
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, all-zero when idle.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port res  output  W  registered result A XOR B.
REQ-011 SHALL have port res_valid  output  1  one-cycle strobe qualifying res and res_id.
REQ-012 SHALL have port res_id  output  clog2(NREQ)  index of the requester owning res.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, EXEC, RESP.
REQ-014 IDLE: any req bit high -> LOAD next edge; otherwise stay IDLE.
REQ-015 LOAD: gnt one-hot for the winner; winner's a/b slices latched into operand registers at end of LOAD; -> EXEC.
REQ-016 EXEC: gnt held; res register loads bitwise (A & ~B) | (~A & B) of the latched operands; -> RESP.
REQ-017 RESP: res_valid=1 and res_id=winner for exactly one cycle, gnt all-zero; any req high -> LOAD (back-to-back, no IDLE), else -> IDLE.
REQ-018 Latency: req sampled at edge k -> res_valid high in cycle k+3; back-to-back throughput one result per 3 cycles.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer ptr, lowest index at or above ptr wins, wrapping modulo NREQ.
REQ-020 ptr SHALL update to (winner+1) mod NREQ on entry to LOAD; NREQ-1 wraps to 0.
REQ-021 The winner SHALL be decided when entering LOAD and SHALL NOT change until the following RESP.
REQ-022 Deassertion of req by the granted requester during LOAD/EXEC SHALL NOT abort the operation; the result still issues.
REQ-023 Operand changes after the LOAD cycle SHALL NOT affect res.
REQ-024 res SHALL hold its last value outside RESP; only res_valid qualifies it.
REQ-025 A single persistent requester with no competitors SHALL be re-granted every 3 cycles.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, ptr 0, gnt 0, busy 0, res 0, res_valid 0, res_id 0.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight operation with no res_valid strobe.
REQ-028 After rst_n release, first arbitration SHALL begin at requester 0.

Structure
REQ-029 Shared package xor_arbiter_pkg SHALL hold the state enum type and default NREQ/W constants.
REQ-030 The XOR datapath SHALL be sub-module xor_unit (W-bit combinational, (a&~b)|(~a&b)), instantiated once.
REQ-031 The arbiter's only registers SHALL be state, ptr, winner index, operand A/B and result.

Verification
REQ-032 Reset, req=0001, a0=0xF0, b0=0x3C -> gnt=0001 in LOAD/EXEC, res_valid cycle k+3, res=0xCC, res_id=0.
REQ-033 req=1111 held, distinct operands -> res_id sequence 0,1,2,3,0, results every 3 cycles, busy never drops.
REQ-034 Only req[3] served, then req=1001 -> requester 0 wins (ptr wrapped to 0).
REQ-035 req[2] dropped and a2 changed to 0xFF during EXEC -> res still A XOR B of LOAD-cycle values, res_id=2.
REQ-036 rst_n pulsed low during EXEC -> all outputs 0 immediately, no res_valid, next grant to lowest active index.
REQ-037 a=0xAA, b=0xAA then a=0x00, b=0xFF -> res 0x00 then 0xFF.
